// File: rtl/uart2ahb_pkg.sv
// Shared AHB constants, command-byte field positions and FSM encodings for the uart2ahb bridge.
package uart2ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // Command byte layout: {hwrite, hsize[2:0], hprot[3:0]}
   localparam int CMD_HWRITE_BIT = 7;
   localparam int CMD_HSIZE_MSB  = 6;
   localparam int CMD_HSIZE_LSB  = 4;
   localparam int CMD_HPROT_MSB  = 3;
   localparam int CMD_HPROT_LSB  = 0;

   typedef enum logic [2:0] {
      PHY_IDLE   = 3'd0,
      PHY_START  = 3'd1,
      PHY_DATA   = 3'd2,
      PHY_PARITY = 3'd3,
      PHY_STOP   = 3'd4
   } phy_state_e;

   typedef enum logic [1:0] {
      F_CMD   = 2'd0,
      F_ADDR  = 2'd1,
      F_DATA  = 2'd2,
      F_ISSUE = 2'd3
   } frame_state_e;

endpackage

// File: rtl/uart_rx_phy.sv
// UART receive PHY: rxd synchroniser, baud counter and bit FSM (8N1).
// With UART_RX_PARITY_EN defined an even-parity bit is expected before the stop bit.
module uart_rx_phy
   import uart2ahb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd_i,
   input  logic [15:0] prescale_i,
   output logic [7:0]  byte_data_o,
   output logic        byte_valid_o,
   output logic        frame_error_o,
`ifdef UART_RX_PARITY_EN
   output logic        parity_error_o,
`endif
   output phy_state_e  state_o
);

   phy_state_e  state_q, state_d;
   logic        meta_q, sync_q, prev_q;
   logic [18:0] cnt_q, cnt_d;
   logic [15:0] presc_q, presc_d, presc_eff;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic [18:0] full_reload;
`ifdef UART_RX_PARITY_EN
   logic        par_q, par_d;
   logic        perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= PHY_IDLE;
         cnt_q   <= '0;
         presc_q <= 16'd1;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         meta_q  <= rxd_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         presc_q <= presc_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      presc_d     = presc_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      valid_d     = 1'b0;
      ferr_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d       = par_q;
      perr_d      = 1'b0;
`endif
      presc_eff   = (prescale_i == 16'd0) ? 16'd1 : prescale_i;
      full_reload = {presc_q, 3'b000} - 19'd1;
      case (state_q)
         PHY_IDLE: begin
            // Counter is loaded for half a bit so START samples mid-bit.
            if (prev_q && !sync_q) begin
               state_d = PHY_START;
               presc_d = presc_eff;
               cnt_d   = {1'b0, presc_eff, 2'b00} - 19'd1;
            end
         end
         PHY_START: begin
            if (cnt_q == '0) begin
               if (sync_q) begin
                  state_d = PHY_IDLE;
               end else begin
                  state_d = PHY_DATA;
                  cnt_d   = full_reload;
                  bit_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         PHY_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               cnt_d   = full_reload;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PHY_PARITY;
`else
                  state_d = PHY_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PHY_PARITY: begin
            if (cnt_q == '0) begin
               par_d   = sync_q;
               cnt_d   = full_reload;
               state_d = PHY_STOP;
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
`endif
         PHY_STOP: begin
            if (cnt_q == '0) begin
               state_d = PHY_IDLE;
               ferr_d  = !sync_q;
`ifdef UART_RX_PARITY_EN
               perr_d  = (par_q != ^shift_q);
               valid_d = sync_q && (par_q == ^shift_q);
`else
               valid_d = sync_q;
`endif
            end else begin
               cnt_d = cnt_q - 19'd1;
            end
         end
         default: state_d = PHY_IDLE;
      endcase
   end

   always_comb begin
      state_o        = state_q;
      byte_data_o    = shift_q;
      byte_valid_o   = valid_q;
      frame_error_o  = ferr_q;
`ifdef UART_RX_PARITY_EN
      parity_error_o = perr_q;
`endif
   end

endmodule

// File: rtl/uart_rx.sv
// UART receive end of the uart2ahb bridge: assembles cmd/address/data frames into one AHB request.
// UART_RX_PARITY_EN enables even parity and adds the parity_error output.
module uart_rx
   import uart2ahb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   output logic [ADDR_WIDTH-1:0] m_haddr_o,
   output logic [1:0]            m_htrans_o,
   output logic                  m_hwrite_o,
   output logic [2:0]            m_hsize_o,
   output logic [2:0]            m_hburst_o,
   output logic [3:0]            m_hprot_o,
   output logic [DATA_WIDTH-1:0] m_hwdata_o,
   output logic                  m_hsel_o,
   input  logic                  m_hready_i,
   output logic                  busy,
   output logic                  frame_error,
`ifdef UART_RX_PARITY_EN
   output logic                  parity_error,
`endif
   output logic                  overrun_error
);

   localparam int ABYTES = ADDR_WIDTH / 8;
   localparam int DBYTES = DATA_WIDTH / 8;
   localparam int MAXB   = (ABYTES > DBYTES) ? ABYTES : DBYTES;
   localparam int CNT_W  = $clog2(MAXB + 1);

   frame_state_e          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  hwrite_q, hwrite_d;
   logic [2:0]            hsize_q, hsize_d;
   logic [3:0]            hprot_q, hprot_d;
   logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
   logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
   logic                  ovr_q, ovr_d;
   logic [7:0]            byte_data;
   logic                  byte_valid, byte_ferr, byte_drop;
   phy_state_e            phy_state;

   uart_rx_phy u_phy (
      .clk            (clk),
      .rst            (rst),
      .rxd_i          (rxd),
      .prescale_i     (prescale),
      .byte_data_o    (byte_data),
      .byte_valid_o   (byte_valid),
      .frame_error_o  (byte_ferr),
`ifdef UART_RX_PARITY_EN
      .parity_error_o (parity_error),
`endif
      .state_o        (phy_state)
   );

`ifdef UART_RX_PARITY_EN
   assign byte_drop = byte_ferr | parity_error;
`else
   assign byte_drop = byte_ferr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= F_CMD;
         cnt_q    <= '0;
         hwrite_q <= 1'b0;
         hsize_q  <= '0;
         hprot_q  <= '0;
         haddr_q  <= '0;
         hwdata_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hwrite_q <= hwrite_d;
         hsize_q  <= hsize_d;
         hprot_q  <= hprot_d;
         haddr_q  <= haddr_d;
         hwdata_q <= hwdata_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hwrite_d = hwrite_q;
      hsize_d  = hsize_q;
      hprot_d  = hprot_q;
      haddr_d  = haddr_q;
      hwdata_d = hwdata_q;
      ovr_d    = 1'b0;
      if (byte_drop) begin
         state_d = F_CMD;
         cnt_d   = '0;
      end else begin
         case (state_q)
            F_CMD: begin
               // hwdata is cleared here so reads present zero write data.
               if (byte_valid) begin
                  hwrite_d = byte_data[CMD_HWRITE_BIT];
                  hsize_d  = byte_data[CMD_HSIZE_MSB:CMD_HSIZE_LSB];
                  hprot_d  = byte_data[CMD_HPROT_MSB:CMD_HPROT_LSB];
                  haddr_d  = '0;
                  hwdata_d = '0;
                  cnt_d    = '0;
                  state_d  = F_ADDR;
               end
            end
            F_ADDR: begin
               if (byte_valid) begin
                  haddr_d = (haddr_q << 8) | ADDR_WIDTH'(byte_data);
                  if (cnt_q == CNT_W'(ABYTES - 1)) begin
                     cnt_d   = '0;
                     state_d = hwrite_q ? F_DATA : F_ISSUE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            F_DATA: begin
               if (byte_valid) begin
                  hwdata_d = (hwdata_q << 8) | DATA_WIDTH'(byte_data);
                  if (cnt_q == CNT_W'(DBYTES - 1)) begin
                     cnt_d   = '0;
                     state_d = F_ISSUE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            F_ISSUE: begin
               ovr_d = byte_valid;
               if (m_hready_i) state_d = F_CMD;
            end
            default: state_d = F_CMD;
         endcase
      end
   end

   always_comb begin
      m_htrans_o = (state_q == F_ISSUE) ? HTRANS_NONSEQ : HTRANS_IDLE;
      m_hsel_o   = (state_q == F_ISSUE);
      busy       = (phy_state != PHY_IDLE) || (state_q != F_CMD);
   end

   assign m_haddr_o     = haddr_q;
   assign m_hwrite_o    = hwrite_q;
   assign m_hsize_o     = hsize_q;
   assign m_hprot_o     = hprot_q;
   assign m_hwdata_o    = hwdata_q;
   assign m_hburst_o    = HBURST_SINGLE;
   assign frame_error   = byte_ferr;
   assign overrun_error = ovr_q;

endmodule
